// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad matrix scanner: rotating active-low column strobe with debounced
// single-key press detection, a one-cycle press pulse and a held flag.
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [DB_W-1:0]   DB_TARGET = DB_W'(DEBOUNCE_CNT);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t            state;
  logic [3:0]        row_m;
  logic [3:0]        row_s;
  logic [3:0]        cap_row;
  logic [SLOT_W-1:0] slot_cnt;
  logic [DB_W-1:0]   stable_cnt;
  logic [DB_W-1:0]   rel_cnt;
  logic [1:0]        col_idx;

  logic              sample;
  logic              one_low;
  logic [1:0]        row_idx;
  logic [1:0]        col_nxt;

  // Row decode: only a pattern with exactly one low line is a key; ghosted
  // multi-low patterns fall through to the default and read as no key.
  always_comb begin
    one_low = 1'b0;
    row_idx = 2'd0;
    case (row_s)
      4'b1110: begin one_low = 1'b1; row_idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; row_idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; row_idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; row_idx = 2'd3; end
      default: begin one_low = 1'b0; row_idx = 2'd0; end
    endcase
  end

  assign sample  = (slot_cnt == SLOT_LAST);
  assign col_nxt = col_idx + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m      <= 4'hF;
      row_s      <= 4'hF;
      cap_row    <= 4'hF;
      slot_cnt   <= '0;
      stable_cnt <= '0;
      rel_cnt    <= '0;
      col_idx    <= 2'd0;
      state      <= SCAN;
      key_col    <= 4'b1110;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      row_m     <= key_row;
      row_s     <= row_m;
      key_valid <= 1'b0;
      slot_cnt  <= sample ? '0 : slot_cnt + SLOT_ONE;
      if (sample) begin
        case (state)
          SCAN: begin
            if (one_low) begin
              cap_row <= row_s;
              if (DB_TARGET == DB_ONE) begin
                key_code   <= {col_idx, row_idx};
                key_valid  <= 1'b1;
                key_held   <= 1'b1;
                stable_cnt <= '0;
                state      <= HOLD;
              end else begin
                stable_cnt <= DB_ONE;
                state      <= DEBOUNCE;
              end
            end else begin
              col_idx <= col_nxt;
              key_col <= ~(4'b0001 << col_nxt);
            end
          end
          DEBOUNCE: begin
            // Column is frozen here, so {col_idx,row_idx} equals the captured code.
            if (row_s == cap_row) begin
              if (stable_cnt + DB_ONE == DB_TARGET) begin
                key_code   <= {col_idx, row_idx};
                key_valid  <= 1'b1;
                key_held   <= 1'b1;
                stable_cnt <= '0;
                state      <= HOLD;
              end else begin
                stable_cnt <= stable_cnt + DB_ONE;
              end
            end else begin
              stable_cnt <= '0;
              col_idx    <= col_nxt;
              key_col    <= ~(4'b0001 << col_nxt);
              state      <= SCAN;
            end
          end
          HOLD: begin
            if (row_s == 4'hF) begin
              if (DB_TARGET == DB_ONE) begin
                key_held <= 1'b0;
                rel_cnt  <= '0;
                col_idx  <= col_nxt;
                key_col  <= ~(4'b0001 << col_nxt);
                state    <= SCAN;
              end else begin
                rel_cnt <= DB_ONE;
                state   <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (row_s == 4'hF) begin
              if (rel_cnt + DB_ONE == DB_TARGET) begin
                key_held <= 1'b0;
                rel_cnt  <= '0;
                col_idx  <= col_nxt;
                key_col  <= ~(4'b0001 << col_nxt);
                state    <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + DB_ONE;
              end
            end else begin
              rel_cnt <= '0;
              state   <= HOLD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: directed scenarios plus random
// row activity, all compared cycle by cycle against a sample-level keypad model.
module tb_keypad_matrix_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DB       = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_row = 4'hF;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // ---------------- reference model: decisions taken once per sample slot ----
  int         m_slot = 0;
  int         m_col = 0;
  int         m_streak = 0;
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_cand = 4'hF;
  logic [3:0] m_code = 4'h0, m_colp = 4'b1110;
  logic       m_valid = 1'b0, m_held = 1'b0;

  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx = 2'd0;
    for (int i = 0; i < 4; i++) if (!r[i]) idx = 2'(i);
    return idx;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [3:0] rs;
    if (rst) begin
      m_slot = 0; m_col = 0; m_streak = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_cand = 4'hF;
      m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
    end else begin
      rs = m_s2;
      m_s2 = m_s1;
      m_s1 = key_row;
      m_valid = 1'b0;
      if (m_slot == SCAN_DIV - 1) begin
        m_slot = 0;
        if (!m_held) begin
          if (m_streak == 0) begin
            if ($countones(~rs) == 1) begin m_cand = rs; m_streak = 1; end
            else m_col = (m_col + 1) % 4;
          end else if (rs == m_cand) begin
            m_streak++;
          end else begin
            m_streak = 0;
            m_col = (m_col + 1) % 4;
          end
          if (m_streak >= DB) begin
            m_held = 1'b1; m_valid = 1'b1; m_streak = 0;
            m_code = {2'(m_col), low_index(m_cand)};
          end
        end else begin
          if (rs == 4'hF) m_streak++;
          else m_streak = 0;
          if (m_streak >= DB) begin
            m_held = 1'b0; m_streak = 0;
            m_col = (m_col + 1) % 4;
          end
        end
      end else begin
        m_slot++;
      end
    end
    m_colp = ~(4'b0001 << m_col);
  end

  // Wait (bounded) for a given column strobe; seen at the first cycle of its slot.
  task automatic wait_col(input logic [3:0] pat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (key_col === pat) ok = 1'b1;
    end
  endtask

  task automatic align_col1(input string name);
    bit ok1, ok2;
    wait_col(4'b1110, ok1);
    wait_col(4'b1101, ok2);
    checks++;
    if (!(ok1 && ok2)) begin
      errors++;
      $display("FAIL %s align: key_col never reached 1101 in budget (last %b)", name, key_col);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_col, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: col=%b code=%b v=%b h=%b, want 1110 0000 0 0",
               key_col, key_code, key_valid, key_held);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle;
    logic [3:0] prev;
    int since, changes;
    prev = key_col; since = 0; changes = 0;
    key_row = 4'hF;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      since++;
      checks++;
      if ({key_col, key_code, key_valid, key_held} !== {m_colp, m_code, m_valid, m_held}) begin
        errors++;
        $display("FAIL idle c%0d: col=%b code=%b v=%b h=%b, want %b %b %b %b", c,
                 key_col, key_code, key_valid, key_held, m_colp, m_code, m_valid, m_held);
      end
      if (key_col !== prev) begin
        checks++;
        if (key_col !== {prev[2:0], prev[3]} || (changes > 0 && since != SCAN_DIV)) begin
          errors++;
          $display("FAIL idle_rotate: col=%b after %0d clks, want %b after %0d",
                   key_col, since, {prev[2:0], prev[3]}, SCAN_DIV);
        end
        changes++; since = 0; prev = key_col;
      end
    end
    checks++;
    if (changes < 7) begin
      errors++;
      $display("FAIL idle_changes: %0d column changes, want at least 7", changes);
    end
  endtask

  task automatic test_press;
    bit seen = 1'b0;
    align_col1("press");
    key_row = 4'b1011;
    for (int c = 0; c < 24 && !seen; c++) begin
      @(negedge clk);
      checks++;
      if ({key_col, key_code, key_valid, key_held} !== {m_colp, m_code, m_valid, m_held}) begin
        errors++;
        $display("FAIL press c%0d: col=%b code=%b v=%b h=%b, want %b %b %b %b", c,
                 key_col, key_code, key_valid, key_held, m_colp, m_code, m_valid, m_held);
      end
      if (key_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || {key_code, key_held, key_col} !== {4'b0110, 1'b1, 4'b1101}) begin
      errors++;
      $display("FAIL press_confirm: seen=%0d code=%b h=%b col=%b, want 1 0110 1 1101",
               seen, key_code, key_held, key_col);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if ({key_valid, key_held, key_col} !== {1'b0, 1'b1, 4'b1101}) begin
        errors++;
        $display("FAIL press_hold c%0d: v=%b h=%b col=%b, want 0 1 1101",
                 c, key_valid, key_held, key_col);
      end
    end
  endtask

  task automatic test_release_bounce;
    for (int i = 0; i < 8 && m_slot != 0; i++) @(negedge clk);
    for (int t = 0; t < 20; t++) begin
      if (t == 0) key_row = 4'hF;
      if (t == 4) key_row = 4'b1011;
      if (t == 5) key_row = 4'hF;
      @(negedge clk);
      checks++;
      if ({key_col, key_code, key_valid, key_held} !== {m_colp, m_code, m_valid, m_held}) begin
        errors++;
        $display("FAIL release t%0d: col=%b code=%b v=%b h=%b, want %b %b %b %b", t,
                 key_col, key_code, key_valid, key_held, m_colp, m_code, m_valid, m_held);
      end
      if (t == 6) begin
        checks++;
        if (key_held !== 1'b1) begin
          errors++;
          $display("FAIL release_bounce: key_held=%b during bounce, want 1", key_held);
        end
      end
    end
    checks++;
    if ({key_held, key_code} !== {1'b0, 4'b0110}) begin
      errors++;
      $display("FAIL release_done: h=%b code=%b, want 0 0110", key_held, key_code);
    end
  endtask

  task automatic test_glitch;
    align_col1("glitch");
    key_row = 4'b0111;
    for (int t = 0; t < 16; t++) begin
      if (t == 4) key_row = 4'hF;
      @(negedge clk);
      checks++;
      if ({key_col, key_code, key_valid, key_held} !== {m_colp, m_code, m_valid, m_held}) begin
        errors++;
        $display("FAIL glitch t%0d: col=%b code=%b v=%b h=%b, want %b %b %b %b", t,
                 key_col, key_code, key_valid, key_held, m_colp, m_code, m_valid, m_held);
      end
      if (t == 7) begin
        checks++;
        if ({key_col, key_valid, key_held} !== {4'b1011, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL glitch_advance: col=%b v=%b h=%b, want 1011 0 0",
                   key_col, key_valid, key_held);
        end
      end
    end
  endtask

  task automatic test_ghost;
    logic [3:0] prev;
    int changes = 0;
    align_col1("ghost");
    prev = key_col;
    key_row = 4'b1001;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      checks++;
      if ({key_col, key_valid, key_held} !== {m_colp, 1'b0, 1'b0} || m_valid) begin
        errors++;
        $display("FAIL ghost t%0d: col=%b v=%b h=%b, want %b 0 0",
                 t, key_col, key_valid, key_held, m_colp);
      end
      if (key_col !== prev) changes++;
      prev = key_col;
    end
    checks++;
    if (changes != 10) begin
      errors++;
      $display("FAIL ghost_scan: %0d column changes in 40 clks, want 10", changes);
    end
    key_row = 4'hF;
  endtask

  task automatic test_reset_hold;
    bit seen = 1'b0;
    repeat (8) @(negedge clk);
    align_col1("rst_hold");
    key_row = 4'b1110;
    for (int c = 0; c < 24 && !seen; c++) begin
      @(negedge clk);
      if (key_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || {key_code, key_held} !== {4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL rst_hold_press: seen=%0d code=%b h=%b, want 1 0100 1", seen, key_code, key_held);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({key_col, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_async: col=%b code=%b v=%b h=%b, want 1110 0000 0 0",
               key_col, key_code, key_valid, key_held);
    end
    repeat (2) @(negedge clk);
    key_row = 4'hF;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({key_col, key_valid, key_held} !== {4'b1110, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_restart: col=%b v=%b h=%b, want 1110 0 0", key_col, key_valid, key_held);
    end
  endtask

  task automatic test_random;
    logic [3:0] pats [10] = '{4'hF, 4'hF, 4'hF, 4'b1110, 4'b1101, 4'b1011, 4'b0111,
                              4'b1001, 4'b0101, 4'b1100};
    int hold = 0;
    logic prev_v = 1'b0;
    for (int c = 0; c < 900; c++) begin
      if (hold == 0) begin
        key_row = pats[$urandom_range(0, 9)];
        hold = $urandom_range(1, 16);
      end
      hold--;
      @(negedge clk);
      checks++;
      if ({key_col, key_code, key_valid, key_held} !== {m_colp, m_code, m_valid, m_held}
          || (prev_v && key_valid)) begin
        errors++;
        $display("FAIL random c%0d: col=%b code=%b v=%b h=%b, want %b %b %b %b", c,
                 key_col, key_code, key_valid, key_held, m_colp, m_code, m_valid, m_held);
      end
      prev_v = key_valid;
    end
    key_row = 4'hF;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press();
    test_release_bounce();
    test_glitch();
    test_ghost();
    test_reset_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clk cycles per column slot (min 4).
REQ-002 Parameter DEBOUNCE_CNT, default 4, consecutive matching slot samples that confirm a press or a release (min 1).
REQ-003 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port key_row  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-006 Port key_col  output  4  column strobe, active-low, exactly one bit low at all times.
REQ-007 Port key_code  output  4  last confirmed key, {col_idx[1:0], row_idx[1:0]}.
REQ-008 Port key_valid  output  1  one-cycle pulse when a press is confirmed.
REQ-009 Port key_held  output  1  high from press confirmation until release confirmation.

Function
REQ-010 key_row shall pass through a 2-flop synchronizer; all decisions use the second-stage value (row_s).
REQ-011 A slot counter shall count 0..SCAN_DIV-1 and wrap; the "sample point" is the cycle with count == SCAN_DIV-1.
REQ-012 col_idx 0..3 selects key_col = ~(1 << col_idx); row_idx is the index of the single low bit of row_s.
REQ-013 FSM states: SCAN, DEBOUNCE, HOLD, RELEASE; a state change and any column change happen only at a sample point.
REQ-014 SCAN: at a sample point, if row_s has exactly one low bit, capture {col_idx,row_idx}, set stable count to 1, go DEBOUNCE, keep col_idx; otherwise advance col_idx (3 wraps to 0).
REQ-015 SCAN: row_s with two or more low bits (ghosting) shall be treated as no key.
REQ-016 DEBOUNCE: at each sample point, if row_s equals the captured row pattern, increment the stable count; otherwise clear the count, advance col_idx and return to SCAN.
REQ-017 DEBOUNCE: when the stable count reaches DEBOUNCE_CNT, load key_code with the captured code, pulse key_valid for exactly one cycle, set key_held, go HOLD.
REQ-018 HOLD: col_idx shall stay frozen; at a sample point with row_s == 4'b1111, set release count to 1 and go RELEASE; any other pattern stays in HOLD.
REQ-019 RELEASE: at each sample point with row_s == 4'b1111, increment the release count; any low bit clears the count and returns to HOLD.
REQ-020 RELEASE: when the release count reaches DEBOUNCE_CNT, clear key_held, advance col_idx, go SCAN; key_code shall retain its value.
REQ-021 Only one key is reported per press; a second key pressed while in HOLD/RELEASE shall not be reported until release is confirmed.
REQ-022 key_valid shall never be high on two consecutive cycles.
REQ-023 Counters shall be sized for their parameter maxima and shall never overflow.

Reset
REQ-024 On rst high: state SCAN, col_idx 0, key_col 4'b1110, key_code 4'b0000, key_valid 0, key_held 0, slot/stable/release counts 0, synchronizer flops 4'b1111.
REQ-025 Reset asserted mid-DEBOUNCE, HOLD or RELEASE shall abort immediately with no key_valid pulse; scanning restarts from column 0 on the first edge after release.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=2)
REQ-026 Idle, row all 1 -> key_col rotates 1110,1101,1011,0111,1110 every 4 clocks; key_valid never asserts.
REQ-027 Hold row=4'b1011 while key_col=1101 -> after 2 matching samples key_code=4'b0110, key_valid single-cycle pulse, key_held=1, key_col frozen at 1101.
REQ-028 Row glitch low for 1 sample only -> return to SCAN, key_valid stays 0, column advances.
REQ-029 Release to 1111 with one bounce low between samples -> key_held stays 1 until 2 consecutive all-high samples, then 0; key_code unchanged.
REQ-030 row=4'b1001 during column scan -> treated as no key; scanning continues, no pulse.
REQ-031 Assert rst during HOLD -> all outputs at reset values asynchronously; key_col=1110 after release.
